sccb_init_sequencer: RTL and testbench

//  Table-driven register initialiser for SCCB/I2C sensors (OV7670-class and successors). Walks an

---
 rtl/sccb_init_sequencer_pkg.sv | 38 +++
 rtl/sccb_init_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_init_sequencer_pkg.sv
// Shared types for the SCCB/I2C table-driven register initialiser.
// The optional readback-verify states exist only when SCCB_INIT_READBACK_EN is defined.
package sccb_init_pkg;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY,
        ST_DONE,
        ST_FAIL
`ifdef SCCB_INIT_READBACK_EN
        ,
        ST_RB_ISSUE,
        ST_RB_WAIT
`endif
    } state_t;

    // Entry kinds; a reg_addr of all ones marks a control word (END or DELAY)
    localparam logic [1:0] KIND_WRITE = 2'd0;
    localparam logic [1:0] KIND_DELAY = 2'd1;
    localparam logic [1:0] KIND_END   = 2'd2;

    // Classify a ROM entry from its all-ones reductions
    function automatic logic [1:0] decode_entry(input logic reg_all_ones,
                                                input logic data_all_ones);
        logic [1:0] kind;
        kind = KIND_WRITE;
        if (reg_all_ones) begin
            kind = data_all_ones ? KIND_END : KIND_DELAY;
        end
        return kind;
    endfunction

endpackage

// File: rtl/sccb_init_sequencer.sv
// Walks a {reg_addr,data} config ROM and issues one register write per entry
// through an I2C master handshake, with delay words, NACK retry and error report.
// Optional readback verify after each write: define SCCB_INIT_READBACK_EN.
module sccb_init_sequencer
    import sccb_init_pkg::*;
#(
    parameter int unsigned ROM_AW     = 8,
    parameter int unsigned REG_AW     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DELAY_UNIT = 100_000,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned AUTO_START = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     init_req,
    output logic                     busy,
    output logic                     init_done,
    output logic                     init_err,
    output logic [ROM_AW-1:0]        err_index,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [REG_AW+DATA_W-1:0] rom_data,
    output logic                     m_start,
    output logic                     m_rd,
    output logic [REG_AW-1:0]        m_reg_addr,
    output logic [DATA_W-1:0]        m_wdata,
    input  logic                     m_ready,
    input  logic                     m_done,
    input  logic                     m_nack,
    input  logic [DATA_W-1:0]        m_rdata
);

    localparam longint unsigned DLY_MAX = (64'd1 << DATA_W) * 64'(DELAY_UNIT);
    localparam int unsigned     DLY_W   = $clog2(DLY_MAX + 64'd1);
    localparam int unsigned     RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [ROM_AW-1:0] ROM_LAST = {ROM_AW{1'b1}};

    state_t             state;
    logic [RTY_W-1:0]   retry;
    logic [DLY_W-1:0]   dly_cnt;

    logic [REG_AW-1:0]  rom_reg_c;
    logic [DATA_W-1:0]  rom_wdata_c;
    logic [1:0]         entry_kind_c;
    logic               can_retry_c;
    logic [DLY_W-1:0]   dly_load_c;

    // Split and classify the ROM word currently presented
    assign {rom_reg_c, rom_wdata_c} = rom_data;
    assign entry_kind_c = decode_entry(&rom_reg_c, &rom_wdata_c);
    assign can_retry_c  = (32'(retry) < MAX_RETRY);
    assign dly_load_c   = DLY_W'((64'(rom_wdata_c) + 64'd1) * 64'(DELAY_UNIT));

`ifdef SCCB_INIT_READBACK_EN
    logic rb_ok_c;
    // Readback passes only on an ACK with matching data
    assign rb_ok_c = !m_nack && (m_rdata == m_wdata);
`else
    logic unused_rdata;
    assign unused_rdata = ^m_rdata;
    assign m_rd = 1'b0;
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            retry      <= '0;
            dly_cnt    <= '0;
            busy       <= 1'b0;
            init_done  <= 1'b0;
            init_err   <= 1'b0;
            err_index  <= '0;
            m_start    <= 1'b0;
            m_reg_addr <= '0;
            m_wdata    <= '0;
`ifdef SCCB_INIT_READBACK_EN
            m_rd       <= 1'b0;
`endif
        end else begin
            m_start <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (init_req || (state == ST_IDLE && AUTO_START != 0)) begin
                        rom_addr  <= '0;
                        retry     <= '0;
                        busy      <= 1'b1;
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (entry_kind_c == KIND_END) begin
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
                    end else if (entry_kind_c == KIND_DELAY) begin
                        dly_cnt <= dly_load_c;
                        state   <= ST_DELAY;
                    end else begin
                        m_reg_addr <= rom_reg_c;
                        m_wdata    <= rom_wdata_c;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef SCCB_INIT_READBACK_EN
                    m_rd <= 1'b0;
`endif
                    if (m_ready) begin
                        m_start <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_done && !m_nack) begin
`ifdef SCCB_INIT_READBACK_EN
                        m_rd  <= 1'b1;
                        state <= ST_RB_ISSUE;
`else
                        retry <= '0;
                        if (rom_addr == ROM_LAST) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            rom_addr <= rom_addr + ROM_AW'(1);
                            state    <= ST_LOAD;
                        end
`endif
                    end else if (m_done) begin
                        if (can_retry_c) begin
                            retry <= retry + RTY_W'(1);
                            state <= ST_ISSUE;
                        end else begin
                            err_index <= rom_addr;
                            init_err  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_FAIL;
                        end
                    end
                end
`ifdef SCCB_INIT_READBACK_EN
                ST_RB_ISSUE: begin
                    if (m_ready) begin
                        m_start <= 1'b1;
                        state   <= ST_RB_WAIT;
                    end
                end
                ST_RB_WAIT: begin
                    if (m_done && rb_ok_c) begin
                        m_rd  <= 1'b0;
                        retry <= '0;
                        if (rom_addr == ROM_LAST) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            rom_addr <= rom_addr + ROM_AW'(1);
                            state    <= ST_LOAD;
                        end
                    end else if (m_done) begin
                        m_rd <= 1'b0;
                        if (can_retry_c) begin
                            retry <= retry + RTY_W'(1);
                            state <= ST_ISSUE;
                        end else begin
                            err_index <= rom_addr;
                            init_err  <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_FAIL;
                        end
                    end
                end
`endif
                ST_DELAY: begin
                    if (dly_cnt <= DLY_W'(1)) begin
                        dly_cnt <= '0;
                        retry   <= '0;
                        if (rom_addr == ROM_LAST) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            rom_addr <= rom_addr + ROM_AW'(1);
                            state    <= ST_LOAD;
                        end
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer: small ROM model and a behavioural
// I2C master with programmable latency, NACK and readback-corruption injection.
module tb_sccb_init_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_req = 1'b0;
    logic        busy, init_done, init_err;
    logic [3:0]  err_index, rom_addr;
    logic [15:0] rom_data = '0;
    logic        m_start, m_rd;
    logic [7:0]  m_reg_addr, m_wdata;
    logic        m_ready = 1'b1;
    logic        m_done = 1'b0;
    logic        m_nack = 1'b0;
    logic [7:0]  m_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;

    sccb_init_sequencer #(
        .ROM_AW(4), .REG_AW(8), .DATA_W(8), .DELAY_UNIT(10), .MAX_RETRY(3), .AUTO_START(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .init_req(init_req), .busy(busy),
        .init_done(init_done), .init_err(init_err), .err_index(err_index),
        .rom_addr(rom_addr), .rom_data(rom_data), .m_start(m_start), .m_rd(m_rd),
        .m_reg_addr(m_reg_addr), .m_wdata(m_wdata), .m_ready(m_ready),
        .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle read latency
    logic [15:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int pcount = 0;
    always @(posedge clk) pcount <= pcount + 1;

    // Master model controls (written by the stimulus process only)
    int         m_lat = 2;
    logic [7:0] nack_reg = 8'h00;
    int         nack_limit = 0;
    int         nack_base = 0;
    logic [7:0] rb_reg = 8'h00;
    int         rb_limit = 0;
    int         rb_base = 0;

    // Transaction log (written by the master model only)
    logic [7:0] log_reg[$];
    logic [7:0] log_data[$];
    logic       log_rd[$];
    int         log_pc[$];
    logic [7:0] shadow [256];

    function automatic int count_txn(input logic [7:0] r, input logic rd, input int base);
        int n = 0;
        for (int i = base; i < log_reg.size(); i++)
            if (log_reg[i] == r && log_rd[i] == rd) n++;
        return n;
    endfunction

    function automatic int count_writes(input int base);
        int n = 0;
        for (int i = base; i < log_reg.size(); i++)
            if (!log_rd[i]) n++;
        return n;
    endfunction

    // Index of the n-th write since base, or -1
    function automatic int nth_write(input int base, input int n);
        int k = 0;
        for (int i = base; i < log_reg.size(); i++) begin
            if (!log_rd[i]) begin
                if (k == n) return i;
                k++;
            end
        end
        return -1;
    endfunction

    bit         in_txn = 1'b0;
    int         txn_cnt = 0;
    logic       txn_nack = 1'b0;
    logic [7:0] txn_rdata = '0;

    // Behavioural I2C master, driven on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            in_txn  = 1'b0;
            m_ready = 1'b1;
            m_done  = 1'b0;
            m_nack  = 1'b0;
        end else if (m_done) begin
            m_done  = 1'b0;
            m_nack  = 1'b0;
            m_ready = 1'b1;
        end else if (in_txn) begin
            if (txn_cnt <= 1) begin
                in_txn  = 1'b0;
                m_done  = 1'b1;
                m_nack  = txn_nack;
                m_rdata = txn_rdata;
            end else begin
                txn_cnt--;
            end
        end else if (m_start) begin
            txn_nack  = 1'b0;
            txn_rdata = '0;
            if (!m_rd) begin
                if (m_reg_addr == nack_reg && count_txn(nack_reg, 1'b0, nack_base) < nack_limit)
                    txn_nack = 1'b1;
                if (!txn_nack) shadow[m_reg_addr] = m_wdata;
            end else begin
                txn_rdata = shadow[m_reg_addr];
                if (m_reg_addr == rb_reg && count_txn(rb_reg, 1'b1, rb_base) < rb_limit)
                    txn_rdata = ~txn_rdata;
            end
            log_reg.push_back(m_reg_addr);
            log_data.push_back(m_wdata);
            log_rd.push_back(m_rd);
            log_pc.push_back(pcount);
            in_txn  = 1'b1;
            txn_cnt = m_lat;
            m_ready = 1'b0;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    // Wait for init_done/init_err; also reports busy on the cycle before
    task automatic wait_end(input int budget, output bit ok, output logic prev_busy);
        logic pb;
        ok = 1'b0;
        pb = busy;
        prev_busy = busy;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done || init_err) begin
                ok = 1'b1;
                prev_busy = pb;
                break;
            end
            pb = busy;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, init_done, init_err, err_index, rom_addr, m_start, m_rd, m_reg_addr, m_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b idx=%h addr=%h start=%b rd=%b reg=%h wd=%h, expected all zero",
                     busy, init_done, init_err, err_index, rom_addr, m_start, m_rd, m_reg_addr, m_wdata);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || rom_addr !== 4'h0) begin
            tests_failed++;
            $display("FAIL idle_without_req: got busy=%b rom_addr=%h, expected busy=0 rom_addr=0", busy, rom_addr);
        end
    endtask

    task automatic test_basic_writes();
        int base; bit ok; logic pb; int i0, i1;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h40D0; rom[2] = 16'hFFFF;
        base = log_reg.size();
        pulse_req();
        wait_end(400, ok, pb);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL basic_timeout: got no completion, expected init_done"); end
        tests_run++;
        if (count_writes(base) !== 2) begin
            tests_failed++; $display("FAIL basic_count: got %0d writes, expected 2", count_writes(base));
        end
        i0 = nth_write(base, 0); i1 = nth_write(base, 1);
        tests_run++;
        if (i0 < 0 || i1 < 0 || log_reg[i0] !== 8'h12 || log_data[i0] !== 8'h80 ||
            log_reg[i1] !== 8'h40 || log_data[i1] !== 8'hD0) begin
            tests_failed++;
            $display("FAIL basic_order: got idx %0d/%0d, expected writes 12:80 then 40:D0", i0, i1);
        end
        tests_run++;
        if (init_done !== 1'b1 || init_err !== 1'b0 || busy !== 1'b0 || pb !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_flags: got done=%b err=%b busy=%b prev_busy=%b, expected 1 0 0 1",
                     init_done, init_err, busy, pb);
        end
    endtask

    task automatic test_delay();
        int base; bit ok; logic pb; int t0; int dt; int i0;
        clear_rom();
        rom[0] = 16'hFF02; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        base = log_reg.size();
        @(negedge clk);
        init_req = 1'b1;
        t0 = pcount;
        @(negedge clk);
        init_req = 1'b0;
        wait_end(400, ok, pb);
        i0 = nth_write(base, 0);
        dt = (i0 >= 0) ? log_pc[i0] - t0 : -1;
        tests_run++;
        if (dt < 30 || dt > 37) begin
            tests_failed++; $display("FAIL delay_latency: got %0d cycles to first start, expected 30..37", dt);
        end
        tests_run++;
        if (!ok || count_writes(base) !== 1 || i0 < 0 || log_reg[i0] !== 8'h11 || log_data[i0] !== 8'h01 || init_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL delay_write: got ok=%b writes=%0d done=%b, expected one write 11:01 and done",
                     ok, count_writes(base), init_done);
        end
    endtask

    task automatic test_retry();
        int base; bit ok; logic pb;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h3456; rom[2] = 16'hFFFF;
        base = log_reg.size();
        nack_reg = 8'h34; nack_limit = 2; nack_base = base;
        pulse_req();
        wait_end(600, ok, pb);
        tests_run++;
        if (count_txn(8'h34, 1'b0, base) !== 3 || count_txn(8'h12, 1'b0, base) !== 1) begin
            tests_failed++;
            $display("FAIL retry_attempts: got reg34=%0d reg12=%0d, expected 3 and 1",
                     count_txn(8'h34, 1'b0, base), count_txn(8'h12, 1'b0, base));
        end
        tests_run++;
        if (!ok || init_done !== 1'b1 || init_err !== 1'b0) begin
            tests_failed++; $display("FAIL retry_done: got done=%b err=%b, expected 1 0", init_done, init_err);
        end
    endtask

    task automatic test_fail();
        int base; bit ok; logic pb; int n_end;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h3456; rom[2] = 16'h5678; rom[3] = 16'hFFFF;
        base = log_reg.size();
        nack_reg = 8'h56; nack_limit = 100; nack_base = base;
        pulse_req();
        wait_end(800, ok, pb);
        tests_run++;
        if (count_txn(8'h56, 1'b0, base) !== 4) begin
            tests_failed++; $display("FAIL fail_attempts: got %0d, expected 4", count_txn(8'h56, 1'b0, base));
        end
        tests_run++;
        if (!ok || init_err !== 1'b1 || init_done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fail_flags: got err=%b done=%b busy=%b, expected 1 0 0", init_err, init_done, busy);
        end
        tests_run++;
        if (err_index !== 4'd2) begin
            tests_failed++; $display("FAIL fail_index: got %0d, expected 2", err_index);
        end
        n_end = log_reg.size();
        repeat (50) @(negedge clk);
        tests_run++;
        if (log_reg.size() !== n_end || init_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL fail_quiet: got %0d extra starts err=%b, expected 0 and 1", log_reg.size() - n_end, init_err);
        end
    endtask

    task automatic test_rerun();
        int base; bit ok; logic pb; int i0, i1, i2;
        nack_limit = 0;
        base = log_reg.size();
        pulse_req();
        tests_run++;
        if (init_err !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL rerun_accept: got err=%b busy=%b, expected 0 1", init_err, busy);
        end
        repeat (6) @(negedge clk);
        pulse_req();
        wait_end(800, ok, pb);
        i0 = nth_write(base, 0); i1 = nth_write(base, 1); i2 = nth_write(base, 2);
        tests_run++;
        if (count_writes(base) !== 3 || i2 < 0 || log_reg[i0] !== 8'h12 || log_reg[i1] !== 8'h34 || log_reg[i2] !== 8'h56) begin
            tests_failed++;
            $display("FAIL rerun_sequence: got %0d writes, expected 12,34,56 once each", count_writes(base));
        end
        tests_run++;
        if (!ok || init_done !== 1'b1 || init_err !== 1'b0) begin
            tests_failed++; $display("FAIL rerun_done: got done=%b err=%b, expected 1 0", init_done, init_err);
        end
    endtask

    task automatic test_wrap();
        int base; bit ok; logic pb; int il;
        for (int i = 0; i < 16; i++) rom[i] = {8'(i + 1), 8'(i * 3)};
        base = log_reg.size();
        pulse_req();
        wait_end(2000, ok, pb);
        il = nth_write(base, 15);
        tests_run++;
        if (count_writes(base) !== 16 || il < 0 || log_reg[il] !== 8'h10 || log_data[il] !== 8'h2D) begin
            tests_failed++;
            $display("FAIL wrap_writes: got %0d writes, expected 16 ending 10:2D", count_writes(base));
        end
        tests_run++;
        if (!ok || init_done !== 1'b1 || init_err !== 1'b0 || rom_addr !== 4'hF) begin
            tests_failed++;
            $display("FAIL wrap_done: got done=%b err=%b addr=%h, expected 1 0 F", init_done, init_err, rom_addr);
        end
    endtask

    task automatic test_reset_mid();
        int base; bit seen;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h40D0; rom[2] = 16'hFFFF;
        m_lat = 40;
        base = log_reg.size();
        pulse_req();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (log_reg.size() > base) begin seen = 1'b1; break; end
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL midreset_start: got no m_start, expected one"); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, init_done, init_err, err_index, rom_addr, m_start, m_rd, m_reg_addr, m_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_async: got busy=%b addr=%h reg=%h wd=%h, expected all zero",
                     busy, rom_addr, m_reg_addr, m_wdata);
        end
        m_lat = 2;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || init_done !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_idle: got busy=%b done=%b, expected 0 0", busy, init_done);
        end
    endtask

`ifdef SCCB_INIT_READBACK_EN
    task automatic test_readback();
        int base; bit ok; logic pb;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h40D0; rom[2] = 16'hFFFF;
        base = log_reg.size();
        rb_reg = 8'h40; rb_limit = 1; rb_base = base;
        pulse_req();
        wait_end(800, ok, pb);
        tests_run++;
        if (count_txn(8'h40, 1'b0, base) !== 2 || count_txn(8'h40, 1'b1, base) !== 2) begin
            tests_failed++;
            $display("FAIL readback_repeat: got w=%0d r=%0d, expected 2 2",
                     count_txn(8'h40, 1'b0, base), count_txn(8'h40, 1'b1, base));
        end
        tests_run++;
        if (!ok || init_done !== 1'b1) begin
            tests_failed++; $display("FAIL readback_done: got done=%b, expected 1", init_done);
        end
    endtask
`endif

    initial begin
        clear_rom();
        test_reset();
        test_basic_writes();
        test_delay();
        test_retry();
        test_fail();
        test_rerun();
        test_wrap();
        test_reset_mid();
`ifdef SCCB_INIT_READBACK_EN
        test_readback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
